// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one single-cycle ALU between two requesters
// Each requester owns a registered response slot so a stalled consumer never blocks the other port.
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int IN_W = 160,
  parameter int ID_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*IN_W-1:0]    req_inputs,
  input  logic [2*ID_W-1:0]    req_id,
  output logic                 alu_new_req,
  output logic [IN_W-1:0]      alu_inputs,
  output logic [ID_W-1:0]      alu_id,
  input  logic [XLEN-1:0]      alu_rd,
  input  logic                 alu_done,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [2*XLEN-1:0]    rsp_data,
  output logic [2*ID_W-1:0]    rsp_id,
  output logic                 grant_err
);

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [2*XLEN-1:0] rsp_data_q,  rsp_data_d;
  logic [2*ID_W-1:0] rsp_id_q,    rsp_id_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_err_q,  grant_err_d;

  logic [1:0] elig;
  logic [1:0] grant;

  // A slot that is being drained this cycle is free for a new capture.
  always_comb begin
    elig  = req_valid & (~rsp_valid_q | rsp_ready);
    grant = 2'b00;
    if (!rst) begin
      case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    req_ready   = grant;
    alu_new_req = |grant;
    alu_inputs  = grant[1] ? req_inputs[2*IN_W-1:IN_W] : req_inputs[IN_W-1:0];
    alu_id      = grant[1] ? req_id[2*ID_W-1:ID_W]     : req_id[ID_W-1:0];
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i]               = 1'b1;
        rsp_data_d[i*XLEN +: XLEN]   = alu_rd;
        rsp_id_d[i*ID_W +: ID_W]     = alu_id;
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
    last_grant_d = (|grant) ? grant[1] : last_grant_q;
    grant_err_d  = grant_err_q | (alu_done != alu_new_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= 1'b1;
      grant_err_q  <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      grant_err_q  <= grant_err_d;
    end
  end

  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
    grant_err = grant_err_q;
  end

endmodule
